rvga_membus_arb: RTL and testbench
==================================

RVGA_MEMBUS_ARB -- requirements
Module: rvga_membus_arb

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, giving the number of requesting membus masters (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, giving the rdata/wdata width of every port.
REQ-003 SHALL have parameter ADDR_W, default 32, giving the address width.
REQ-004 SHALL have parameter RR_MODE, default 1: 1 = round-robin, 0 = fixed priority with index 0 highest.
REQ-005 SHALL have parameter TIMEOUT, default 255, giving the maximum grant-to-resp cycles (0 = watchdog disabled).
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port m_addr_i, input, N_MASTERS x ADDR_W: per-master address.
REQ-009 SHALL have port m_read_i, input, N_MASTERS: per-master read request.
REQ-010 SHALL have port m_write_i, input, N_MASTERS: per-master write request.
REQ-011 SHALL have port m_wdata_i, input, N_MASTERS x DATA_W: per-master write data.
REQ-012 SHALL have port m_rdata_o, output, DATA_W: read data broadcast to all masters.
REQ-013 SHALL have port m_resp_o, output, N_MASTERS: per-master one-cycle completion.
REQ-014 SHALL have port m_err_o, output, N_MASTERS: per-master timeout flag, qualified by m_resp_o.
REQ-015 SHALL have ports s_addr_o/s_read_o/s_write_o/s_wdata_o as outputs and s_rdata_i/s_resp_i as inputs, forming the downstream membus (widths ADDR_W, 1, 1, DATA_W, DATA_W, 1).

Function
REQ-016 SHALL treat master i as requesting while m_read_i[i] or m_write_i[i] is high; masters hold the request until their resp.
REQ-017 SHALL implement states IDLE and BUSY only.
REQ-018 In IDLE with at least one request, SHALL register a grant and enter BUSY on the next edge; with no request, SHALL remain in IDLE.
REQ-019 In RR_MODE=1, SHALL select the first requester searching upward from (last granted + 1) mod N_MASTERS; the last-granted register resets to N_MASTERS-1, so master 0 wins first.
REQ-020 In RR_MODE=0, SHALL select the lowest-index requester.
REQ-021 In BUSY, SHALL drive s_addr_o/s_read_o/s_write_o/s_wdata_o combinationally from the granted master's inputs; in IDLE, SHALL drive all of them to 0.
REQ-022 In BUSY, SHALL drive m_resp_o[g] equal to s_resp_i in the same cycle and then return to IDLE on that edge; other m_resp_o bits SHALL stay 0.
REQ-023 SHALL drive m_rdata_o equal to s_rdata_i at all times.
REQ-024 SHALL give minimum latency of 1 cycle from request to downstream request, and 2 cycles to the earliest resp.
REQ-025 SHALL keep one transaction outstanding at most; back-to-back grants SHALL be separated by one IDLE cycle.
REQ-026 SHALL count BUSY cycles when TIMEOUT>0; on reaching TIMEOUT without s_resp_i, SHALL pulse m_resp_o[g] and m_err_o[g] for one cycle, deassert downstream read/write, and return to IDLE.
REQ-027 If s_resp_i and the timeout coincide, SHALL treat the transaction as normal completion with m_err_o=0.
REQ-028 If the granted master drops its request before resp (protocol error), SHALL hold the grant until resp or timeout.
REQ-029 SHALL forward read and write both high unchanged and SHALL NOT resolve that case.

Reset
REQ-030 On rst low, SHALL immediately force state IDLE, counter 0, last-granted N_MASTERS-1, and m_resp_o/m_err_o/s_read_o/s_write_o 0, including mid-transaction.
REQ-031 After rst release, SHALL accept a grant no earlier than the first rising edge.

Structure
REQ-032 SHALL place the state enum (IDLE/BUSY) in rvga_types.
REQ-033 SHALL implement the round-robin/priority selection in one sub-module, rvga_rr_pick (request vector and last index in, one-hot grant out, combinational).
REQ-034 SHALL be instantiable between ifetch/memory membus ports and a single DDR port, or between the l1ic/l1id caches and DDR with DATA_W=128.

Verification
REQ-035 Single master (N=2): m_read_i=01, addr 0x100, resp after 3 cycles -> s_addr_o=0x100 one cycle after the request, m_resp_o=01 for exactly one cycle.
REQ-036 Round-robin contention: both masters read continuously, resp after 1 cycle -> grants alternate 0,1,0,1; m_resp_o pulses alternate 01,10.
REQ-037 Fixed priority (RR_MODE=0): both masters request continuously -> master 0 granted every time; master 1 starves.
REQ-038 Timeout (TIMEOUT=4): master 1 writes and s_resp_i stays 0 -> m_resp_o=10 and m_err_o=10 on the 4th BUSY cycle, then IDLE.
REQ-039 Reset mid-BUSY: assert rst low between edges -> s_read_o=0 and state IDLE without waiting for a clock; after release, master 0 wins the first grant.
REQ-040 Coincident resp and timeout (TIMEOUT=3, resp on cycle 3) -> m_err_o=0 and m_resp_o pulses once.

Source files
------------

// File: rtl/rvga_types.sv
// ----------------------------------------------------------------------------
// rvga_types
// Shared type definitions for the rvga membus arbiter.
//   state_t : arbiter FSM state (IDLE = ready to grant, BUSY = one
//             transaction outstanding on the downstream membus)
// ----------------------------------------------------------------------------
package rvga_types;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage : rvga_types

// File: rtl/rvga_rr_pick.sv
// ----------------------------------------------------------------------------
// rvga_rr_pick
// Combinational grant selection for the membus arbiter.
//   RR_MODE = 1 : first requester searching upward from (i_last + 1) mod N
//   RR_MODE = 0 : lowest-index requester (index 0 highest priority)
// Ports:
//   i_req  [N_MASTERS-1:0] : request vector
//   i_last [IDX_W-1:0]     : index of the last granted master
//   o_gnt  [N_MASTERS-1:0] : one-hot grant (all zero when no request)
// ----------------------------------------------------------------------------
module rvga_rr_pick #(
    parameter int N_MASTERS = 2,
    parameter int RR_MODE   = 1,
    parameter int IDX_W     = 1
) (
    input  logic [N_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last,
    output logic [N_MASTERS-1:0] o_gnt
);

    generate
        if (RR_MODE != 0) begin : g_rr
            logic             w_found;
            logic [IDX_W-1:0] w_idx;

            // Walk the N candidates starting just after the last winner;
            // the first one requesting takes the grant.
            always_comb begin
                o_gnt   = '0;
                w_found = 1'b0;
                w_idx   = '0;
                for (int k = 1; k <= N_MASTERS; k++) begin
                    w_idx = IDX_W'((int'(i_last) + k) % N_MASTERS);
                    if (!w_found && i_req[w_idx]) begin
                        o_gnt[w_idx] = 1'b1;
                        w_found      = 1'b1;
                    end
                end
            end
        end else begin : g_fixed
            logic w_unused_last;

            // Isolate the lowest set bit of the request vector.
            assign o_gnt         = i_req & (~i_req + N_MASTERS'(1));
            assign w_unused_last = ^i_last;
        end
    endgenerate

endmodule : rvga_rr_pick

// File: rtl/rvga_membus_arb.sv
// ----------------------------------------------------------------------------
// rvga_membus_arb
// N-master to single-slave membus arbiter with one outstanding transaction,
// round-robin or fixed-priority selection and a grant-to-resp watchdog.
// Ports:
//   clk, rst (async, active low)
//   m_addr_i/m_read_i/m_write_i/m_wdata_i : packed per-master request buses
//   m_rdata_o                             : read data broadcast to all masters
//   m_resp_o/m_err_o                      : per-master completion / timeout flag
//   s_addr_o/s_read_o/s_write_o/s_wdata_o : downstream request
//   s_rdata_i/s_resp_i                    : downstream response
// ----------------------------------------------------------------------------
module rvga_membus_arb
    import rvga_types::*;
#(
    parameter int N_MASTERS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int RR_MODE   = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr_i,
    input  logic [N_MASTERS-1:0]        m_read_i,
    input  logic [N_MASTERS-1:0]        m_write_i,
    input  logic [N_MASTERS*DATA_W-1:0] m_wdata_i,
    output logic [DATA_W-1:0]           m_rdata_o,
    output logic [N_MASTERS-1:0]        m_resp_o,
    output logic [N_MASTERS-1:0]        m_err_o,
    output logic [ADDR_W-1:0]           s_addr_o,
    output logic                        s_read_o,
    output logic                        s_write_o,
    output logic [DATA_W-1:0]           s_wdata_o,
    input  logic [DATA_W-1:0]           s_rdata_i,
    input  logic                        s_resp_i
);

    localparam int IDX_W = $clog2(N_MASTERS);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t               r_state, w_state_next;
    logic [IDX_W-1:0]     r_gnt_idx, w_gnt_idx_next;
    logic [IDX_W-1:0]     r_last, w_last_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic [N_MASTERS-1:0] w_req;
    logic [N_MASTERS-1:0] w_pick;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_timeout;
    logic [ADDR_W-1:0]    w_addr  [N_MASTERS];
    logic [DATA_W-1:0]    w_wdata [N_MASTERS];

    genvar gi;
    generate
        for (gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
            assign w_addr[gi]  = m_addr_i[gi*ADDR_W +: ADDR_W];
            assign w_wdata[gi] = m_wdata_i[gi*DATA_W +: DATA_W];
            assign w_req[gi]   = m_read_i[gi] | m_write_i[gi];
        end
    endgenerate

    rvga_rr_pick #(
        .N_MASTERS (N_MASTERS),
        .RR_MODE   (RR_MODE),
        .IDX_W     (IDX_W)
    ) u_pick (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_pick)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (w_pick[k]) begin
                w_pick_idx = w_pick_idx | IDX_W'(k);
            end
        end
    end

    // The watchdog fires in the TIMEOUT-th BUSY cycle; a resp arriving in
    // that same cycle wins and the transaction completes normally.
    generate
        if (TIMEOUT > 0) begin : g_wdog
            assign w_timeout = (r_state == BUSY) && (r_cnt == CNT_W'(TIMEOUT - 1)) && !s_resp_i;
        end else begin : g_no_wdog
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign m_rdata_o = s_rdata_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_gnt_idx <= '0;
            r_last    <= IDX_W'(N_MASTERS - 1);
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_gnt_idx <= w_gnt_idx_next;
            r_last    <= w_last_next;
            r_cnt     <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_gnt_idx_next = r_gnt_idx;
        w_last_next    = r_last;
        w_cnt_next     = r_cnt;
        s_addr_o       = '0;
        s_read_o       = 1'b0;
        s_write_o      = 1'b0;
        s_wdata_o      = '0;
        m_resp_o       = '0;
        m_err_o        = '0;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_state_next   = BUSY;
                    w_gnt_idx_next = w_pick_idx;
                    w_last_next    = w_pick_idx;
                    w_cnt_next     = '0;
                end
            end
            BUSY: begin
                // The grant is held even if the master drops its request;
                // only resp or the watchdog ends the transaction.
                s_addr_o  = w_addr[r_gnt_idx];
                s_wdata_o = w_wdata[r_gnt_idx];
                s_read_o  = m_read_i[r_gnt_idx] & ~w_timeout;
                s_write_o = m_write_i[r_gnt_idx] & ~w_timeout;
                if (s_resp_i || w_timeout) begin
                    m_resp_o[r_gnt_idx] = 1'b1;
                    m_err_o[r_gnt_idx]  = w_timeout;
                    w_state_next        = IDLE;
                    w_cnt_next          = '0;
                end else if (TIMEOUT > 0) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule : rvga_membus_arb

// File: tb/tb_rvga_membus_arb.sv
// ----------------------------------------------------------------------------
// tb_rvga_membus_arb
// Two arbiter instances share the master-side stimulus:
//   dut_a : round-robin, TIMEOUT=4
//   dut_b : fixed priority, TIMEOUT=3
// Each has its own slave model answering lat_x cycles into a transaction
// (lat_x = 0 never answers) with rdata = address + 0x1000.
// ----------------------------------------------------------------------------
module tb_rvga_membus_arb;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N*AW-1:0] m_addr;
    logic [N-1:0]    m_read, m_write;
    logic [N*DW-1:0] m_wdata;

    logic [DW-1:0] m_rdata_a, s_wdata_a, s_rdata_a;
    logic [N-1:0]  m_resp_a, m_err_a;
    logic [AW-1:0] s_addr_a;
    logic          s_read_a, s_write_a, s_resp_a;

    logic [DW-1:0] m_rdata_b, s_wdata_b, s_rdata_b;
    logic [N-1:0]  m_resp_b, m_err_b;
    logic [AW-1:0] s_addr_b;
    logic          s_read_b, s_write_b, s_resp_b;

    int lat_a = 1, lat_b = 1, scnt_a = 0, scnt_b = 0;

    typedef struct {
        logic [N-1:0]  resp;
        logic [N-1:0]  err;
        logic [DW-1:0] rdata;
        bit            chk_rdata;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    rvga_membus_arb #(.N_MASTERS(N), .DATA_W(DW), .ADDR_W(AW), .RR_MODE(1), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .m_addr_i(m_addr), .m_read_i(m_read), .m_write_i(m_write),
        .m_wdata_i(m_wdata), .m_rdata_o(m_rdata_a), .m_resp_o(m_resp_a), .m_err_o(m_err_a),
        .s_addr_o(s_addr_a), .s_read_o(s_read_a), .s_write_o(s_write_a), .s_wdata_o(s_wdata_a),
        .s_rdata_i(s_rdata_a), .s_resp_i(s_resp_a));

    rvga_membus_arb #(.N_MASTERS(N), .DATA_W(DW), .ADDR_W(AW), .RR_MODE(0), .TIMEOUT(3)) dut_b (
        .clk(clk), .rst(rst), .m_addr_i(m_addr), .m_read_i(m_read), .m_write_i(m_write),
        .m_wdata_i(m_wdata), .m_rdata_o(m_rdata_b), .m_resp_o(m_resp_b), .m_err_o(m_err_b),
        .s_addr_o(s_addr_b), .s_read_o(s_read_b), .s_write_o(s_write_b), .s_wdata_o(s_wdata_b),
        .s_rdata_i(s_rdata_b), .s_resp_i(s_resp_b));

    // Slave models
    assign s_resp_a  = (lat_a != 0) && (s_read_a || s_write_a) && (scnt_a == lat_a - 1);
    assign s_resp_b  = (lat_b != 0) && (s_read_b || s_write_b) && (scnt_b == lat_b - 1);
    assign s_rdata_a = s_addr_a + 32'h1000;
    assign s_rdata_b = s_addr_b + 32'h1000;

    always @(posedge clk) begin
        if (!(s_read_a || s_write_a) || s_resp_a) scnt_a <= 0;
        else                                      scnt_a <= scnt_a + 1;
        if (!(s_read_b || s_write_b) || s_resp_b) scnt_b <= 0;
        else                                      scnt_b <= scnt_b + 1;
    end

    task automatic do_reset;
        m_read  = '0;
        m_write = '0;
        m_addr  = {32'h0000_0200, 32'h0000_0100};
        m_wdata = {32'h2222_2222, 32'h1111_1111};
        rst     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Observes only: waits (bounded) for a resp pulse on the selected DUT.
    task automatic wait_resp(input bit sel_b, input int max_cyc, output bit got,
                             output logic [N-1:0] resp, output logic [N-1:0] err,
                             output logic [DW-1:0] rdata, output int cyc);
        got = 1'b0; cyc = 0; resp = '0; err = '0; rdata = '0;
        for (int c = 1; c <= max_cyc && !got; c++) begin
            @(negedge clk);
            if ((sel_b ? m_resp_b : m_resp_a) != '0) begin
                got   = 1'b1;
                cyc   = c;
                resp  = sel_b ? m_resp_b : m_resp_a;
                err   = sel_b ? m_err_b : m_err_a;
                rdata = sel_b ? m_rdata_b : m_rdata_a;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; m_read = 2'b11; m_write = '0;
        m_addr = {32'h0000_0200, 32'h0000_0100};
        repeat (2) @(negedge clk);
        n_checks++; if (s_read_a !== 1'b0) $display("FAIL rst_s_read: got %b want 0", s_read_a); else n_pass++;
        n_checks++; if (s_addr_a !== '0) $display("FAIL rst_s_addr: got %h want 0", s_addr_a); else n_pass++;
        n_checks++; if (m_resp_a !== '0 || m_err_a !== '0) $display("FAIL rst_resp_err: got %b/%b want 00/00", m_resp_a, m_err_a); else n_pass++;
        n_checks++; if (s_read_b !== 1'b0) $display("FAIL rst_s_read_b: got %b want 0", s_read_b); else n_pass++;
        n_checks++; if (m_rdata_a !== 32'h1000) $display("FAIL rdata_passthru: got %h want 00001000", m_rdata_a); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (s_read_a !== 1'b0) $display("FAIL grant_before_edge: got %b want 0", s_read_a); else n_pass++;
        @(negedge clk);
        n_checks++; if (s_read_a !== 1'b1 || s_addr_a !== 32'h100) $display("FAIL first_grant: got rd=%b addr=%h want rd=1 addr=00000100", s_read_a, s_addr_a); else n_pass++;
        m_read = '0;
    endtask

    task automatic test_single;
        bit got; logic [N-1:0] r, e; logic [DW-1:0] d; int cyc; exp_t x;
        do_reset();
        lat_a = 3; m_read = 2'b01;
        sb.push_back('{resp: 2'b01, err: 2'b00, rdata: 32'h1100, chk_rdata: 1'b1});
        #1;
        n_checks++; if (s_read_a !== 1'b0) $display("FAIL single_idle: got s_read %b want 0", s_read_a); else n_pass++;
        @(negedge clk);
        n_checks++; if (s_addr_a !== 32'h100 || s_read_a !== 1'b1) $display("FAIL single_req: got rd=%b addr=%h want rd=1 addr=00000100", s_read_a, s_addr_a); else n_pass++;
        wait_resp(1'b0, 8, got, r, e, d, cyc);
        x = sb.pop_front();
        $display("txn single a: resp=%b err=%b rdata=%h cyc=%0d", r, e, d, cyc);
        n_checks++; if (!got) $display("FAIL single_resp_wait: got no resp want resp"); else n_pass++;
        n_checks++; if (r !== x.resp || e !== x.err || d !== x.rdata) $display("FAIL single_resp: got %b/%b/%h want %b/%b/%h", r, e, d, x.resp, x.err, x.rdata); else n_pass++;
        n_checks++; if (cyc !== 2) $display("FAIL single_latency: got %0d want 2", cyc); else n_pass++;
        @(negedge clk);
        n_checks++; if (m_resp_a !== '0) $display("FAIL single_pulse_len: got %b want 00", m_resp_a); else n_pass++;
        m_read = '0;
    endtask

    task automatic test_rw_both;
        do_reset();
        lat_a = 1; m_read = 2'b01; m_write = 2'b01;
        @(negedge clk);
        n_checks++; if (s_read_a !== 1'b1 || s_write_a !== 1'b1) $display("FAIL rw_both: got rd=%b wr=%b want 1/1", s_read_a, s_write_a); else n_pass++;
        m_read = '0; m_write = '0;
    endtask

    task automatic test_round_robin;
        bit got; logic [N-1:0] r, e; logic [DW-1:0] d; int cyc; exp_t x;
        do_reset();
        lat_a = 1; m_read = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sb.push_back('{resp: 2'b01, err: 2'b00, rdata: 32'h1100, chk_rdata: 1'b1});
            else            sb.push_back('{resp: 2'b10, err: 2'b00, rdata: 32'h1200, chk_rdata: 1'b1});
        end
        for (int i = 0; i < 4; i++) begin
            wait_resp(1'b0, 6, got, r, e, d, cyc);
            x = sb.pop_front();
            $display("txn rr a #%0d: resp=%b err=%b rdata=%h cyc=%0d", i, r, e, d, cyc);
            n_checks++; if (!got || r !== x.resp || e !== x.err || d !== x.rdata) $display("FAIL rr_txn%0d: got %b/%b/%h want %b/%b/%h", i, r, e, d, x.resp, x.err, x.rdata); else n_pass++;
            if (i > 0) begin
                n_checks++; if (cyc !== 2) $display("FAIL rr_spacing%0d: got %0d want 2", i, cyc); else n_pass++;
            end
        end
        m_read = '0;
    endtask

    task automatic test_fixed_priority;
        bit got; logic [N-1:0] r, e; logic [DW-1:0] d; int cyc; exp_t x;
        do_reset();
        lat_b = 1; m_read = 2'b11;
        for (int i = 0; i < 4; i++) sb.push_back('{resp: 2'b01, err: 2'b00, rdata: 32'h1100, chk_rdata: 1'b1});
        for (int i = 0; i < 4; i++) begin
            wait_resp(1'b1, 6, got, r, e, d, cyc);
            x = sb.pop_front();
            $display("txn fp b #%0d: resp=%b err=%b rdata=%h cyc=%0d", i, r, e, d, cyc);
            n_checks++; if (!got || r !== x.resp || e !== x.err || d !== x.rdata) $display("FAIL fp_txn%0d: got %b/%b/%h want %b/%b/%h", i, r, e, d, x.resp, x.err, x.rdata); else n_pass++;
        end
        m_read = '0;
    endtask

    task automatic test_timeout;
        bit got; logic [N-1:0] r, e; logic [DW-1:0] d; int cyc; exp_t x;
        do_reset();
        lat_a = 0;
        m_addr[AW +: AW]  = 32'h0000_0300;
        m_wdata[DW +: DW] = 32'hDEAD_BEEF;
        m_write = 2'b10;
        sb.push_back('{resp: 2'b10, err: 2'b10, rdata: 32'h0, chk_rdata: 1'b0});
        @(negedge clk);
        n_checks++; if (s_write_a !== 1'b1 || s_addr_a !== 32'h300 || s_wdata_a !== 32'hDEAD_BEEF) $display("FAIL to_fwd: got wr=%b addr=%h wd=%h want 1/00000300/deadbeef", s_write_a, s_addr_a, s_wdata_a); else n_pass++;
        wait_resp(1'b0, 8, got, r, e, d, cyc);
        x = sb.pop_front();
        $display("txn timeout a: resp=%b err=%b cyc=%0d", r, e, cyc);
        n_checks++; if (!got || r !== x.resp || e !== x.err) $display("FAIL to_resp: got %b/%b want %b/%b", r, e, x.resp, x.err); else n_pass++;
        n_checks++; if (cyc !== 3) $display("FAIL to_cycle: got busy cycle %0d want 4", cyc + 1); else n_pass++;
        n_checks++; if (s_write_a !== 1'b0) $display("FAIL to_deassert: got %b want 0", s_write_a); else n_pass++;
        @(negedge clk);
        n_checks++; if (m_resp_a !== '0 || s_write_a !== 1'b0) $display("FAIL to_idle: got resp=%b wr=%b want 00/0", m_resp_a, s_write_a); else n_pass++;
        m_write = '0;
    endtask

    task automatic test_reset_mid_busy;
        bit got; logic [N-1:0] r, e; logic [DW-1:0] d; int cyc; exp_t x;
        do_reset();
        lat_a = 0; m_read = 2'b10;
        @(negedge clk);
        n_checks++; if (s_read_a !== 1'b1) $display("FAIL mid_busy: got %b want 1", s_read_a); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (s_read_a !== 1'b0 || s_addr_a !== '0) $display("FAIL mid_rst_async: got rd=%b addr=%h want 0/0", s_read_a, s_addr_a); else n_pass++;
        m_read = 2'b11; lat_a = 1;
        @(negedge clk);
        rst = 1'b1;
        sb.push_back('{resp: 2'b01, err: 2'b00, rdata: 32'h1100, chk_rdata: 1'b1});
        wait_resp(1'b0, 4, got, r, e, d, cyc);
        x = sb.pop_front();
        $display("txn post-reset a: resp=%b err=%b rdata=%h cyc=%0d", r, e, d, cyc);
        n_checks++; if (!got || r !== x.resp || d !== x.rdata || cyc !== 1) $display("FAIL mid_rst_regrant: got %b/%h cyc=%0d want %b/%h cyc=1", r, d, cyc, x.resp, x.rdata); else n_pass++;
        m_read = '0;
    endtask

    task automatic test_coincident;
        bit got; logic [N-1:0] r, e; logic [DW-1:0] d; int cyc; exp_t x;
        do_reset();
        lat_b = 3; m_read = 2'b01;
        sb.push_back('{resp: 2'b01, err: 2'b00, rdata: 32'h1100, chk_rdata: 1'b1});
        wait_resp(1'b1, 8, got, r, e, d, cyc);
        x = sb.pop_front();
        $display("txn coincident b: resp=%b err=%b rdata=%h cyc=%0d", r, e, d, cyc);
        n_checks++; if (!got || r !== x.resp || e !== x.err || (x.chk_rdata && d !== x.rdata)) $display("FAIL coin_resp: got %b/%b/%h want %b/%b/%h", r, e, d, x.resp, x.err, x.rdata); else n_pass++;
        n_checks++; if (cyc !== 3) $display("FAIL coin_cycle: got %0d want 3", cyc); else n_pass++;
        @(negedge clk);
        n_checks++; if (m_resp_b !== '0 || m_err_b !== '0) $display("FAIL coin_once: got %b/%b want 00/00", m_resp_b, m_err_b); else n_pass++;
        m_read = '0;
    endtask

    initial begin
        m_read = '0; m_write = '0; m_addr = '0; m_wdata = '0;
        #1;
        test_reset();
        test_single();
        test_rw_both();
        test_round_robin();
        test_fixed_priority();
        test_timeout();
        test_reset_mid_busy();
        test_coincident();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule : tb_rvga_membus_arb
